npu_shell: RTL and testbench

Top-level NPU bring-up shell. It provides an MMIO register file and a command-queue (CQ) descriptor fetcher, and executes DMA_COPY descriptors through an internal AXI4 master DMA engine. It contains a small on-chip SRAM mapped at 0x8000_0000. It sits between the host (MMIO, CQ memory port, IRQ) and the system AXI memory fabric.

---
 rtl/npu_shell.sv | 276 +++++++++++++++++++++++++++
 tb/tb_npu_shell.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_shell.sv
// NPU bring-up shell: MMIO register file, command-queue descriptor fetcher and a
// single-beat AXI4 master copy engine with a small internal SRAM window.
`timescale 1ns/1ps
module npu_shell #(
    parameter int          MMIO_ADDR_W = 12,
    parameter int          DATA_W      = 32,
    parameter int          SRAM_BYTES  = 4096,
    parameter logic [63:0] SRAM_BASE   = 64'h8000_0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [MMIO_ADDR_W-1:0] mmio_addr,
    input  logic                   mmio_we,
    input  logic [DATA_W-1:0]      mmio_wdata,
    output logic [DATA_W-1:0]      mmio_rdata,
    output logic                   irq,
    output logic                   dma_req_valid,
    output logic [63:0]            dma_req_src,
    output logic [63:0]            dma_req_dst,
    output logic [31:0]            dma_req_bytes,
    input  logic                   dma_req_ready,
    input  logic                   dma_resp_done,
    output logic [63:0]            cq_mem_addr,
    input  logic [255:0]           cq_mem_rdata,
    output logic                   m_axi_awvalid,
    input  logic                   m_axi_awready,
    output logic [63:0]            m_axi_awaddr,
    output logic [7:0]             m_axi_awlen,
    output logic [2:0]             m_axi_awsize,
    output logic                   m_axi_wvalid,
    input  logic                   m_axi_wready,
    output logic [255:0]           m_axi_wdata,
    output logic [31:0]            m_axi_wstrb,
    output logic                   m_axi_wlast,
    input  logic                   m_axi_bvalid,
    output logic                   m_axi_bready,
    output logic                   m_axi_arvalid,
    input  logic                   m_axi_arready,
    output logic [63:0]            m_axi_araddr,
    output logic [7:0]             m_axi_arlen,
    output logic [2:0]             m_axi_arsize,
    input  logic                   m_axi_rvalid,
    output logic                   m_axi_rready,
    input  logic [255:0]           m_axi_rdata,
    input  logic                   m_axi_rlast
);
    localparam int SRAM_DEPTH = SRAM_BYTES / 32;
    localparam int SRAM_AW    = $clog2(SRAM_DEPTH);
    localparam logic [MMIO_ADDR_W-1:0] A_VERSION = 'h000, A_CAPS = 'h004, A_STATUS = 'h008,
        A_CONTROL = 'h00C, A_IRQ_STATUS = 'h010, A_IRQ_ENABLE = 'h014, A_CQ_BASE_LO = 'h020,
        A_CQ_BASE_HI = 'h024, A_CQ_SIZE = 'h028, A_CQ_HEAD = 'h02C, A_CQ_TAIL = 'h030,
        A_DOORBELL = 'h040;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_RD, S_RD_SRAM, S_RD_DATA, S_WR, S_WR_RESP
    } state_t;
    state_t state_reg, state_next;

    logic [DATA_W-1:0] control_reg, cq_base_lo_reg, cq_base_hi_reg, cq_size_reg;
    logic [DATA_W-1:0] cq_head_reg, cq_tail_reg;
    logic [2:0]        irq_status_reg, irq_enable_reg, irq_hw_set;
    logic              run_reg;
    logic [7:0]        op_reg;
    logic [63:0]       src_reg, dst_reg, cur_src_reg, cur_dst_reg;
    logic [31:0]       size_reg;
    logic [27:0]       beats_reg;
    logic [255:0]      data_reg, sram_q_reg;
    logic              aw_done_reg, w_done_reg;
    logic [255:0]      sram_mem [SRAM_DEPTH];

    logic run_clear, set_empty, set_event, set_error, head_adv;
    logic load_desc, start_dma, latch_sram, latch_axi, beat_done;
    logic src_sram, dst_sram;
    logic [32:0]       size_rnd;
    logic [27:0]       beats_init;
    logic [DATA_W:0]   head_sum;
    logic [DATA_W-1:0] head_next;

    function automatic logic is_sram(input logic [63:0] a);
        return (a[63:32] == SRAM_BASE[63:32]) && (a[31] == SRAM_BASE[31]);
    endfunction

    assign src_sram   = is_sram(cur_src_reg);
    assign dst_sram   = is_sram(cur_dst_reg);
    assign size_rnd   = {1'b0, size_reg} + 33'd31;
    assign beats_init = size_rnd[32:5];
    // The head wraps to zero once the next slot would reach the ring size; size 0 means an unbounded ring.
    assign head_sum   = {1'b0, cq_head_reg} + (DATA_W+1)'(32);
    assign head_next  = ((cq_size_reg != '0) && (head_sum >= {1'b0, cq_size_reg})) ? '0 : head_sum[DATA_W-1:0];
    assign irq_hw_set = {set_error, set_event, set_empty};

    always_comb begin
        state_next = state_reg;
        run_clear  = 1'b0;
        set_empty  = 1'b0;
        set_event  = 1'b0;
        set_error  = 1'b0;
        head_adv   = 1'b0;
        load_desc  = 1'b0;
        start_dma  = 1'b0;
        latch_sram = 1'b0;
        latch_axi  = 1'b0;
        beat_done  = 1'b0;
        case (state_reg)
            S_IDLE: if (run_reg) begin
                if (cq_head_reg != cq_tail_reg) state_next = S_FETCH;
                else begin
                    run_clear = 1'b1;
                    set_empty = 1'b1;
                end
            end
            S_FETCH: begin
                load_desc  = 1'b1;
                state_next = S_DECODE;
            end
            S_DECODE: begin
                state_next = S_IDLE;
                if (op_reg == 8'h00) head_adv = 1'b1;
                else if (op_reg == 8'h01) begin
                    if (beats_init == '0) begin
                        set_event = 1'b1;
                        head_adv  = 1'b1;
                    end else begin
                        start_dma  = 1'b1;
                        state_next = S_RD;
                    end
                end else begin
                    set_error = 1'b1;
                    head_adv  = 1'b1;
                end
            end
            S_RD: begin
                if (src_sram) state_next = S_RD_SRAM;
                else if (m_axi_arready) state_next = S_RD_DATA;
            end
            S_RD_SRAM: begin
                latch_sram = 1'b1;
                state_next = S_WR;
            end
            S_RD_DATA: if (m_axi_rvalid) begin
                latch_axi  = 1'b1;
                state_next = S_WR;
            end
            S_WR: begin
                if (dst_sram) beat_done = 1'b1;
                else if ((aw_done_reg || m_axi_awready) && (w_done_reg || m_axi_wready))
                    state_next = S_WR_RESP;
            end
            S_WR_RESP: if (m_axi_bvalid) beat_done = 1'b1;
            default: state_next = S_IDLE;
        endcase
        if (beat_done) begin
            if (beats_reg == 28'd1) begin
                set_event  = 1'b1;
                head_adv   = 1'b1;
                state_next = S_IDLE;
            end else begin
                state_next = S_RD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            control_reg    <= '0;
            cq_base_lo_reg <= '0;
            cq_base_hi_reg <= '0;
            cq_size_reg    <= '0;
            cq_head_reg    <= '0;
            cq_tail_reg    <= '0;
            irq_enable_reg <= '0;
            run_reg        <= 1'b0;
            op_reg         <= '0;
            src_reg        <= '0;
            dst_reg        <= '0;
            size_reg       <= '0;
            cur_src_reg    <= '0;
            cur_dst_reg    <= '0;
            beats_reg      <= '0;
            data_reg       <= '0;
            aw_done_reg    <= 1'b0;
            w_done_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (mmio_we && mmio_addr == A_CONTROL)    control_reg    <= mmio_wdata;
            if (mmio_we && mmio_addr == A_CQ_BASE_LO) cq_base_lo_reg <= mmio_wdata;
            if (mmio_we && mmio_addr == A_CQ_BASE_HI) cq_base_hi_reg <= mmio_wdata;
            if (mmio_we && mmio_addr == A_CQ_SIZE)    cq_size_reg    <= mmio_wdata;
            if (mmio_we && mmio_addr == A_CQ_TAIL)    cq_tail_reg    <= mmio_wdata;
            if (mmio_we && mmio_addr == A_IRQ_ENABLE) irq_enable_reg <= mmio_wdata[2:0];
            // A doorbell in the same cycle as the empty check keeps the queue running.
            run_reg <= (run_reg && !run_clear) || (mmio_we && mmio_addr == A_DOORBELL);
            if (head_adv) cq_head_reg <= head_next;
            if (load_desc) begin
                op_reg   <= cq_mem_rdata[7:0];
                src_reg  <= cq_mem_rdata[127:64];
                dst_reg  <= cq_mem_rdata[191:128];
                size_reg <= cq_mem_rdata[223:192];
            end
            if (start_dma) begin
                cur_src_reg <= src_reg;
                cur_dst_reg <= dst_reg;
                beats_reg   <= beats_init;
            end else if (beat_done) begin
                cur_src_reg <= cur_src_reg + 64'd32;
                cur_dst_reg <= cur_dst_reg + 64'd32;
                beats_reg   <= beats_reg - 28'd1;
            end
            if (latch_sram) data_reg <= sram_q_reg;
            else if (latch_axi) data_reg <= m_axi_rdata;
            aw_done_reg <= (state_next == S_WR) && (aw_done_reg || (m_axi_awvalid && m_axi_awready));
            w_done_reg  <= (state_next == S_WR) && (w_done_reg || (m_axi_wvalid && m_axi_wready));
        end
    end

    // Hardware set is OR-ed after the W1C mask so a same-cycle event is never lost.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_irq
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) irq_status_reg[gi] <= 1'b0;
                else irq_status_reg[gi] <= irq_hw_set[gi] ||
                    (irq_status_reg[gi] && !(mmio_we && mmio_addr == A_IRQ_STATUS && mmio_wdata[gi]));
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        sram_q_reg <= sram_mem[cur_src_reg[5 +: SRAM_AW]];
        if (state_reg == S_WR && dst_sram) sram_mem[cur_dst_reg[5 +: SRAM_AW]] <= data_reg;
    end

    always_comb begin
        mmio_rdata = '0;
        case (mmio_addr)
            A_VERSION:    mmio_rdata = DATA_W'(32'h0001_0000);
            A_CAPS:       mmio_rdata = DATA_W'(32'h0000_0001);
            A_STATUS:     mmio_rdata = DATA_W'({dma_req_valid, state_reg != S_IDLE});
            A_CONTROL:    mmio_rdata = control_reg;
            A_IRQ_STATUS: mmio_rdata = DATA_W'(irq_status_reg);
            A_IRQ_ENABLE: mmio_rdata = DATA_W'(irq_enable_reg);
            A_CQ_BASE_LO: mmio_rdata = cq_base_lo_reg;
            A_CQ_BASE_HI: mmio_rdata = cq_base_hi_reg;
            A_CQ_SIZE:    mmio_rdata = cq_size_reg;
            A_CQ_HEAD:    mmio_rdata = cq_head_reg;
            A_CQ_TAIL:    mmio_rdata = cq_tail_reg;
            default:      mmio_rdata = '0;
        endcase
    end

    assign irq           = |(irq_status_reg & irq_enable_reg);
    assign dma_req_valid = (state_reg == S_RD) || (state_reg == S_RD_SRAM) || (state_reg == S_RD_DATA) ||
                           (state_reg == S_WR) || (state_reg == S_WR_RESP);
    assign dma_req_src   = src_reg;
    assign dma_req_dst   = dst_reg;
    assign dma_req_bytes = size_reg;
    assign cq_mem_addr   = {cq_base_hi_reg, cq_base_lo_reg} + 64'(cq_head_reg);

    assign m_axi_arvalid = (state_reg == S_RD) && !src_sram;
    assign m_axi_araddr  = cur_src_reg;
    assign m_axi_arlen   = 8'd0;
    assign m_axi_arsize  = 3'd5;
    assign m_axi_rready  = (state_reg == S_RD_DATA);
    assign m_axi_awvalid = (state_reg == S_WR) && !dst_sram && !aw_done_reg;
    assign m_axi_awaddr  = cur_dst_reg;
    assign m_axi_awlen   = 8'd0;
    assign m_axi_awsize  = 3'd5;
    assign m_axi_wvalid  = (state_reg == S_WR) && !dst_sram && !w_done_reg;
    assign m_axi_wdata   = data_reg;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = 1'b1;
    assign m_axi_bready  = (state_reg == S_WR_RESP);

    logic unused_ok;
    assign unused_ok = ^{dma_req_ready, dma_resp_done, m_axi_rlast, cq_mem_rdata[63:8], cq_mem_rdata[255:224]};
endmodule

// File: tb/tb_npu_shell.sv
// Directed bench for npu_shell: MMIO registers, CQ descriptor flow, AXI/SRAM copies,
// IRQ masking/W1C and AXI backpressure, against a sparse memory model.
`timescale 1ns/1ps
module tb_npu_shell;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [11:0]  mmio_addr = '0;
    logic         mmio_we = 1'b0;
    logic [31:0]  mmio_wdata = '0;
    logic [31:0]  mmio_rdata;
    logic         irq, dma_req_valid;
    logic [63:0]  dma_req_src, dma_req_dst, cq_mem_addr;
    logic [31:0]  dma_req_bytes;
    logic [255:0] cq_mem_rdata = '0;
    logic         awvalid, awready = 1'b0, wvalid, wready = 1'b0, wlast, bvalid = 1'b0, bready;
    logic [63:0]  awaddr, araddr;
    logic [7:0]   awlen, arlen;
    logic [2:0]   awsize, arsize;
    logic [255:0] wdata, rdata = '0;
    logic [31:0]  wstrb;
    logic         arvalid, arready = 1'b0, rvalid = 1'b0, rready;

    npu_shell dut (
        .clk(clk), .rst_n(rst_n), .mmio_addr(mmio_addr), .mmio_we(mmio_we), .mmio_wdata(mmio_wdata),
        .mmio_rdata(mmio_rdata), .irq(irq), .dma_req_valid(dma_req_valid), .dma_req_src(dma_req_src),
        .dma_req_dst(dma_req_dst), .dma_req_bytes(dma_req_bytes), .dma_req_ready(1'b1),
        .dma_resp_done(1'b0), .cq_mem_addr(cq_mem_addr), .cq_mem_rdata(cq_mem_rdata),
        .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
        .m_axi_awsize(awsize), .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata),
        .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
        .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr), .m_axi_arlen(arlen),
        .m_axi_arsize(arsize), .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
        .m_axi_rlast(rvalid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [255:0] mem [logic [63:0]];

    function automatic logic [255:0] mem_rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return '0;
    endfunction

    function automatic logic [255:0] pat(input logic [63:0] a);
        return {a ^ 64'h0123_4567_89AB_CDEF, ~a, a + 64'h1111, a ^ 64'hFFFF_0000_FFFF_0000};
    endfunction

    // AXI slave with programmable ready delay; decisions made on the falling edge.
    int bp_delay = 0;
    int ar_wait, aw_wait, w_wait, ar_cnt, aw_cnt;
    bit r_pend, r_show, aw_got, w_got, b_show, ar_seen, aw_seen, w_seen;
    logic [63:0]  r_addr, aw_addr, ar_first, aw_first;
    logic [255:0] w_data, w_first;

    always @(negedge clk) begin
        if (!rst_n) begin
            arready = 0; awready = 0; wready = 0; rvalid = 0; bvalid = 0;
            ar_wait = 0; aw_wait = 0; w_wait = 0; ar_cnt = 0; aw_cnt = 0;
            r_pend = 0; r_show = 0; aw_got = 0; w_got = 0; b_show = 0;
            ar_seen = 0; aw_seen = 0; w_seen = 0;
        end else begin
            if (r_show) begin rvalid = 0; r_show = 0; end
            else if (r_pend) begin rdata = mem_rd(r_addr); rvalid = 1; r_show = 1; r_pend = 0; end
            if (b_show) begin bvalid = 0; b_show = 0; end
            else if (aw_got && w_got) begin
                mem[aw_addr] = w_data; bvalid = 1; b_show = 1; aw_got = 0; w_got = 0;
            end
            arready = 0;
            if (arvalid) begin
                if (!ar_seen) begin ar_seen = 1; ar_first = araddr; end
                if (ar_wait >= bp_delay) begin
                    if (bp_delay > 0) check("araddr_held", araddr, ar_first);
                    arready = 1; r_pend = 1; r_addr = araddr; ar_cnt++; ar_seen = 0; ar_wait = 0;
                end else ar_wait++;
            end else begin
                if (ar_seen) check("arvalid_held", arvalid, 1);
                ar_seen = 0; ar_wait = 0;
            end
            awready = 0;
            if (awvalid) begin
                if (!aw_seen) begin aw_seen = 1; aw_first = awaddr; end
                if (aw_wait >= bp_delay) begin
                    if (bp_delay > 0) check("awaddr_held", awaddr, aw_first);
                    awready = 1; aw_got = 1; aw_addr = awaddr; aw_cnt++; aw_seen = 0; aw_wait = 0;
                end else aw_wait++;
            end else begin
                if (aw_seen) check("awvalid_held", awvalid, 1);
                aw_seen = 0; aw_wait = 0;
            end
            wready = 0;
            if (wvalid) begin
                if (!w_seen) begin w_seen = 1; w_first = wdata; end
                if (w_wait >= bp_delay) begin
                    if (bp_delay > 0) check("wdata_held", wdata, w_first);
                    wready = 1; w_got = 1; w_data = wdata; w_seen = 0; w_wait = 0;
                end else w_wait++;
            end else begin
                if (w_seen) check("wvalid_held", wvalid, 1);
                w_seen = 0; w_wait = 0;
            end
            cq_mem_rdata = mem_rd(cq_mem_addr);
        end
    end

    // Descriptor fields must not move while dma_req_valid is up.
    int stab_viol = 0;
    logic prev_valid = 1'b0;
    logic [63:0] prev_src, prev_dst;
    logic [31:0] prev_bytes;
    always @(negedge clk) begin
        if (prev_valid && dma_req_valid &&
            (dma_req_src != prev_src || dma_req_dst != prev_dst || dma_req_bytes != prev_bytes))
            stab_viol++;
        prev_valid = dma_req_valid; prev_src = dma_req_src; prev_dst = dma_req_dst; prev_bytes = dma_req_bytes;
    end

    task automatic mmio_wr(input logic [11:0] a, input logic [31:0] d);
        @(negedge clk);
        mmio_addr = a; mmio_wdata = d; mmio_we = 1'b1;
        @(negedge clk);
        mmio_we = 1'b0;
        $display("txn mmio_wr addr=%03h data=%08h", a, d);
    endtask

    task automatic mmio_rd(input logic [11:0] a, output logic [31:0] d);
        @(negedge clk);
        mmio_addr = a;
        #1 d = mmio_rdata;
    endtask

    task automatic do_reset();
        mmio_we = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic put_desc(input logic [63:0] a, input logic [7:0] op, input logic [63:0] src,
                            input logic [63:0] dst, input logic [31:0] size);
        logic [255:0] w;
        w = '0;
        w[7:0] = op; w[23:16] = 8'd1; w[127:64] = src; w[191:128] = dst; w[223:192] = size;
        mem[a] = w;
    endtask

    task automatic setup_cq(input logic [31:0] size);
        mmio_wr(12'h020, 32'h0);
        mmio_wr(12'h024, 32'h10);
        mmio_wr(12'h028, size);
    endtask

    task automatic wait_head(input string tag, input logic [31:0] exp, input int budget);
        logic [31:0] h;
        h = '1;
        for (int i = 0; i < budget; i++) begin
            mmio_rd(12'h02C, h);
            if (h == exp) break;
        end
        check(tag, h, exp);
        repeat (4) @(negedge clk);
        $display("txn queue drained head=%0d", h);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [63:0] CQB = 64'h10_0000_0000;

    initial begin
        logic [31:0] d;
        logic [63:0] s1, d1;
        int k;

        do_reset();
        mmio_rd(12'h000, d); check("version", d, 32'h0001_0000);
        mmio_rd(12'h004, d); check("caps", d, 32'h1);
        mmio_rd(12'h02C, d); check("reset_head", d, 0);
        mmio_rd(12'h100, d); check("unmapped", d, 0);
        check("reset_irq", irq, 0);
        check("reset_valids", {arvalid, awvalid, wvalid, dma_req_valid}, 0);

        // Single 4 KiB DMA_COPY between external buffers.
        s1 = 64'h30_0000_0000; d1 = 64'h30_0010_0000;
        for (int i = 0; i < 128; i++) mem[s1 + 64'(32 * i)] = pat(s1 + 64'(32 * i));
        put_desc(CQB, 8'h01, s1, d1, 32'd4096);
        setup_cq(32'h1000);
        mmio_wr(12'h030, 32'd32);
        mmio_wr(12'h040, 32'h1);
        for (k = 0; k < 5; k++) begin
            @(negedge clk);
            if (dma_req_valid) break;
        end
        check("req_valid_latency", dma_req_valid, 1);
        check("req_src", dma_req_src, s1);
        check("req_dst", dma_req_dst, d1);
        check("req_bytes", dma_req_bytes, 32'd4096);
        $display("txn dma_copy src=%0h dst=%0h bytes=4096", s1, d1);
        wait_head("head_copy4k", 32'd32, 3000);
        mmio_rd(12'h010, d); check("irq_status_copy4k", d, 32'h3);
        for (int i = 0; i < 128; i++) check("dst4k_word", mem_rd(d1 + 64'(32 * i)), pat(s1 + 64'(32 * i)));
        check("req_stable", stab_viol, 0);

        // Two chained descriptors through the internal SRAM.
        do_reset();
        for (int i = 0; i < 8; i++) mem[64'(32 * i)] = pat(64'(32 * i));
        put_desc(CQB, 8'h01, 64'h0, 64'h8000_0000, 32'd256);
        put_desc(CQB + 64'd32, 8'h01, 64'h8000_0000, 64'h1_0000, 32'd256);
        setup_cq(32'h1000);
        mmio_wr(12'h030, 32'd64);
        mmio_wr(12'h040, 32'h1);
        wait_head("head_sram", 32'd64, 2000);
        mmio_rd(12'h010, d); check("irq_status_sram", d, 32'h3);
        for (int i = 0; i < 8; i++) check("sram_rt_word", mem_rd(64'h1_0000 + 64'(32 * i)), pat(64'(32 * i)));
        check("sram_ar_count", ar_cnt, 8);
        check("sram_aw_count", aw_cnt, 8);

        // IRQ masking and write-one-to-clear.
        check("irq_masked", irq, 0);
        mmio_wr(12'h014, 32'h2);
        #1 check("irq_event_enabled", irq, 1);
        @(negedge clk);
        mmio_addr = 12'h010; mmio_wdata = 32'h2; mmio_we = 1'b1;
        @(posedge clk);
        #1 check("irq_after_w1c", irq, 0);
        @(negedge clk);
        mmio_we = 1'b0;
        mmio_rd(12'h010, d); check("irq_status_after_w1c", d, 32'h1);
        mmio_wr(12'h014, 32'h1);
        #1 check("irq_empty_enabled", irq, 1);

        // Bad opcode, NOP, zero-size copy and ring wrap.
        do_reset();
        put_desc(CQB, 8'h7F, 64'h40, 64'h80, 32'd64);
        put_desc(CQB + 64'd32, 8'h00, 64'h40, 64'h80, 32'd64);
        put_desc(CQB + 64'd64, 8'h01, 64'h5000, 64'h6000, 32'd0);
        setup_cq(32'd96);
        mmio_wr(12'h030, 32'd32);
        mmio_wr(12'h040, 32'h1);
        wait_head("head_badop", 32'd32, 200);
        mmio_rd(12'h010, d); check("irq_status_badop", d, 32'h5);
        mmio_wr(12'h030, 32'd0);
        mmio_wr(12'h040, 32'h1);
        wait_head("head_wrap", 32'd0, 200);
        mmio_rd(12'h010, d); check("irq_status_wrap", d, 32'h7);
        mmio_rd(12'h008, d); check("status_idle", d, 32'h0);
        check("ctrl_ar_count", ar_cnt, 0);
        check("ctrl_aw_count", aw_cnt, 0);
        check("size0_no_write", mem_rd(64'h6000), 256'h0);

        // Backpressure on every address/data channel with a partial last beat.
        do_reset();
        bp_delay = 10;
        for (int i = 0; i < 4; i++) mem[64'h2000 + 64'(32 * i)] = pat(64'h2000 + 64'(32 * i));
        put_desc(CQB, 8'h01, 64'h2000, 64'h3000, 32'd100);
        setup_cq(32'h1000);
        mmio_wr(12'h030, 32'd32);
        mmio_wr(12'h040, 32'h1);
        wait_head("head_bp", 32'd32, 2000);
        for (int i = 0; i < 4; i++) check("bp_dst_word", mem_rd(64'h3000 + 64'(32 * i)), pat(64'h2000 + 64'(32 * i)));
        check("bp_no_extra_beat", mem_rd(64'h3080), 256'h0);
        check("bp_ar_count", ar_cnt, 4);
        check("bp_aw_count", aw_cnt, 4);
        check("bp_req_stable", stab_viol, 0);
        bp_delay = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
